// File: rtl/program_sequencer_ctrl.sv
// Program-flow controller: reset hold sequence, pm_addr/pc generation, jumps and run/halt/step debug.
// Optional breakpoint comparator enabled by defining PROG_SEQ_BREAKPOINT_EN.
`timescale 1ns/1ps

module program_sequencer_ctrl #(
    parameter int unsigned RESET_HOLD_CYCLES = 4,
    parameter logic [7:0]  START_ADDR        = 8'h00
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       jmp,
    input  logic       jmp_nz,
    input  logic [3:0] jmp_addr,
    input  logic       dont_jmp,
    input  logic       run_req,
    input  logic       halt_req,
    input  logic       step_req,
    output logic [7:0] pm_addr,
    output logic [7:0] pc,
    output logic       sync_reset,
    output logic       hold,
    output logic       halted,
    output logic       step_ack
`ifdef PROG_SEQ_BREAKPOINT_EN
    ,
    input  logic       bp_en,
    input  logic [7:0] bp_addr,
    output logic       bp_hit
`endif
);

    typedef enum logic [1:0] {
        ST_RST,
        ST_RUN,
        ST_HALT,
        ST_STEP
    } state_t;

    localparam logic [3:0] HOLD_LAST = 4'(RESET_HOLD_CYCLES - 1);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] hold_cnt;
    logic [3:0] hold_cnt_nxt;
    logic [7:0] run_addr;

`ifdef PROG_SEQ_BREAKPOINT_EN
    logic bp_now;
    logic bp_sticky;
`endif

    // Address the core fetches when executing (RUN or STEP).
    always_comb begin
        if (jmp || (jmp_nz && !dont_jmp)) begin
            run_addr = {pc[7:4], jmp_addr};
        end else begin
            run_addr = pc + 8'd1;
        end
    end

    always_comb begin
        state_nxt    = state;
        hold_cnt_nxt = hold_cnt;
        pm_addr      = pc;
        sync_reset   = 1'b0;
        hold         = 1'b0;
        halted       = 1'b0;
        step_ack     = 1'b0;
`ifdef PROG_SEQ_BREAKPOINT_EN
        bp_now       = 1'b0;
`endif
        case (state)
            ST_RST: begin
                pm_addr      = START_ADDR;
                sync_reset   = 1'b1;
                hold         = 1'b1;
                hold_cnt_nxt = hold_cnt + 4'd1;
                if (hold_cnt == HOLD_LAST) begin
                    state_nxt    = ST_RUN;
                    hold_cnt_nxt = '0;
                end
            end
            ST_RUN: begin
                pm_addr = run_addr;
                if (halt_req) begin
                    state_nxt = ST_HALT;
                end
`ifdef PROG_SEQ_BREAKPOINT_EN
                // pc takes pm_addr on the edge, so it lands exactly on bp_addr.
                if (bp_en && (run_addr == bp_addr)) begin
                    bp_now    = 1'b1;
                    state_nxt = ST_HALT;
                end
`endif
            end
            ST_HALT: begin
                hold   = 1'b1;
                halted = 1'b1;
                if (run_req) begin
                    state_nxt = ST_RUN;
                end else if (step_req) begin
                    state_nxt = ST_STEP;
                end
            end
            ST_STEP: begin
                pm_addr   = run_addr;
                step_ack  = 1'b1;
                state_nxt = ST_HALT;
            end
            default: begin
                state_nxt = ST_RST;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_RST;
            hold_cnt <= '0;
            pc       <= START_ADDR;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_cnt_nxt;
            pc       <= pm_addr;
        end
    end

`ifdef PROG_SEQ_BREAKPOINT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bp_sticky <= 1'b0;
        end else if ((state == ST_HALT) && run_req) begin
            bp_sticky <= 1'b0;
        end else if (bp_now) begin
            bp_sticky <= 1'b1;
        end
    end

    assign bp_hit = bp_sticky | bp_now;
`endif

endmodule

// File: tb/tb_program_sequencer_ctrl.sv
// Self-checking bench for program_sequencer_ctrl: directed scenarios plus random stimulus
// compared every cycle against a behavioural model of the sequencer.
`timescale 1ns/1ps

module tb_program_sequencer_ctrl;

    localparam int unsigned HOLD  = 4;
    localparam logic [7:0]  START = 8'h00;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       jmp, jmp_nz, dont_jmp, run_req, halt_req, step_req;
    logic [3:0] jmp_addr;
    logic [7:0] pm_addr, pc;
    logic       sync_reset, hold, halted, step_ack;
    logic       bp_en;
    logic [7:0] bp_addr;
`ifdef PROG_SEQ_BREAKPOINT_EN
    logic       bp_hit;
`endif

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Model: cycles of reset hold left, halted/stepping flags, program counter, sticky breakpoint.
    int unsigned m_rst_left;
    bit          m_halt, m_step, m_bp;
    logic [7:0]  m_pc;

    program_sequencer_ctrl #(
        .RESET_HOLD_CYCLES(HOLD),
        .START_ADDR(START)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .jmp(jmp),
        .jmp_nz(jmp_nz),
        .jmp_addr(jmp_addr),
        .dont_jmp(dont_jmp),
        .run_req(run_req),
        .halt_req(halt_req),
        .step_req(step_req),
        .pm_addr(pm_addr),
        .pc(pc),
        .sync_reset(sync_reset),
        .hold(hold),
        .halted(halted),
        .step_ack(step_ack)
`ifdef PROG_SEQ_BREAKPOINT_EN
        ,
        .bp_en(bp_en),
        .bp_addr(bp_addr),
        .bp_hit(bp_hit)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called one time unit after a rising edge; reset held for two edges, then released.
    task automatic apply_reset();
        reset_n = 1'b0;
        #1;
        m_rst_left = HOLD;
        m_halt = 0;
        m_step = 0;
        m_bp   = 0;
        m_pc   = START;
        check("rst_halted", halted, 1'b0);
        check("rst_sync", sync_reset, 1'b1);
        check("rst_hold", hold, 1'b1);
        check("rst_pc", pc, START);
        check("rst_ack", step_ack, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_pc_held", pc, START);
        reset_n = 1'b1;
    endtask

    // One clock cycle: drive inputs, compare all outputs against the model, advance the model.
    task automatic tick(input logic j, input logic jn, input logic [3:0] a, input logic dj,
                        input logic rr, input logic hr, input logic sr);
        logic [7:0] e_pm;
        logic       e_sync, e_hold, e_halted, e_ack, e_bp, bp_match;
        jmp = j; jmp_nz = jn; jmp_addr = a; dont_jmp = dj;
        run_req = rr; halt_req = hr; step_req = sr;
        #2;
        e_sync = 0; e_hold = 0; e_halted = 0; e_ack = 0; bp_match = 0;
        if (m_rst_left > 0) begin
            e_pm = START; e_sync = 1; e_hold = 1;
        end else if (m_halt) begin
            e_pm = m_pc; e_hold = 1; e_halted = 1;
        end else begin
            e_pm  = (j || (jn && !dj)) ? {m_pc[7:4], a} : m_pc + 8'd1;
            e_ack = m_step;
`ifdef PROG_SEQ_BREAKPOINT_EN
            bp_match = !m_step && bp_en && (e_pm == bp_addr);
`endif
        end
        e_bp = m_bp | bp_match;
        check("pm_addr", pm_addr, e_pm);
        check("pc", pc, m_pc);
        check("sync_reset", sync_reset, e_sync);
        check("hold", hold, e_hold);
        check("halted", halted, e_halted);
        check("step_ack", step_ack, e_ack);
`ifdef PROG_SEQ_BREAKPOINT_EN
        check("bp_hit", bp_hit, e_bp);
`endif
        if (m_rst_left > 0) begin
            m_rst_left--;
        end else if (m_halt) begin
            if (rr) begin
                m_halt = 0; m_bp = 0;
            end else if (sr) begin
                m_halt = 0; m_step = 1;
            end
        end else if (m_step) begin
            m_step = 0; m_halt = 1;
        end else begin
            if (hr) m_halt = 1;
            if (bp_match) begin
                m_halt = 1; m_bp = 1;
            end
        end
        m_pc = e_pm;
        @(posedge clk); #1;
    endtask

    task automatic idle();
        tick(0, 0, 4'h0, 0, 0, 0, 0);
    endtask

    task automatic run_to(input logic [7:0] target);
        for (int i = 0; i < 300 && m_pc != target; i++) idle();
        check("reach_pc", pc, target);
    endtask

    initial begin
        reset_n = 1'b1;
        jmp = 0; jmp_nz = 0; jmp_addr = '0; dont_jmp = 0;
        run_req = 0; halt_req = 0; step_req = 0;
        bp_en = 0; bp_addr = '0;
        @(posedge clk); #1;

        // Reset sequence, debug requests ignored while in hold
        apply_reset();
        for (int i = 0; i < HOLD; i++) tick(1, 0, 4'h9, 0, 1, 1, 1);
        check("seq_sync_off", sync_reset, 1'b0);
        check("seq_pc0", pc, 8'h00);
        idle();
        check("seq_pc1", pc, 8'h01);
        idle();
        check("seq_pc2", pc, 8'h02);

        // Jumps
        run_to(8'h3A);
        tick(1, 0, 4'h5, 0, 0, 0, 0);
        check("jmp_pc", pc, 8'h35);
        run_to(8'h72);
        tick(0, 1, 4'hC, 1, 0, 0, 0);
        check("jnz_not_taken", pc, 8'h73);
        tick(0, 1, 4'h2, 0, 0, 0, 0);
        tick(0, 1, 4'hC, 0, 0, 0, 0);
        check("jnz_taken", pc, 8'h7C);

        // Wrap
        run_to(8'hFE);
        idle();
        check("wrap_ff", pc, 8'hFF);
        idle();
        check("wrap_00", pc, 8'h00);

        // Halt / step, jumps ignored in HALT
        apply_reset();
        run_to(8'h10);
        tick(0, 0, 4'h0, 0, 0, 1, 0);
        check("halt_entered", halted, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick(1, 1, 4'h3, 0, 0, 1, 0);
            check("halt_frozen", pc, 8'h11);
        end
        tick(0, 0, 4'h0, 0, 0, 0, 1);
        check("step_pulse", step_ack, 1'b1);
        tick(0, 0, 4'h0, 0, 1, 0, 0);
        check("step_pc", pc, 8'h12);
        check("step_back_halt", halted, 1'b1);
        tick(0, 0, 4'h0, 0, 1, 0, 1);
        check("run_wins", halted, 1'b0);
        check("run_no_ack", step_ack, 1'b0);

        // Reset while halted
        tick(0, 0, 4'h0, 0, 0, 1, 0);
        apply_reset();
        for (int i = 0; i < HOLD; i++) idle();
        check("rst_mid_run", hold, 1'b0);

`ifdef PROG_SEQ_BREAKPOINT_EN
        apply_reset();
        bp_en = 1; bp_addr = 8'h08;
        for (int i = 0; i < 40 && !m_halt; i++) idle();
        check("bp_pc", pc, 8'h08);
        check("bp_set", bp_hit, 1'b1);
        tick(0, 0, 4'h0, 0, 1, 0, 0);
        check("bp_clear", bp_hit, 1'b0);
        idle();
        check("bp_resume_pc", pc, 8'h09);
        bp_en = 0;
`endif

        // Random phase
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 149) == 0) apply_reset();
`ifdef PROG_SEQ_BREAKPOINT_EN
            bp_en = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 15) == 0) bp_addr = 8'($urandom);
`endif
            tick($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0, 4'($urandom),
                 1'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 2) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
